iter_shifter: RTL and testbench
===============================

# iter_shifter

Multi-cycle, parametrised shift/rotate unit for the 32-bit RISC datapath. It is the successor to the single-cycle combinational shifter. It supports logical, arithmetic and rotate modes and a shift amount taken from an operand. The shift advances up to STEP bit positions per clock, trading latency for area. Valid/ready handshakes on input and output let the ALU/EX stage stall on it.

## Interface
- WIDTH, 32: data width; power of two, ≥ 8.
- STEP, 4: maximum bit positions shifted per cycle; power of two, 1..WIDTH.
- AW, $clog2(WIDTH): shift-amount width (derived localparam, not overridable).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- op  in  3  0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5–7 reserved.
- data  in  WIDTH  operand to shift.
- amt  in  AW  shift amount, 0..WIDTH-1.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  shifted value.
- carry_out  out  1  last bit shifted out; present only with SHIFTER_CARRY_EN.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid, latch op, data and amt into internal registers, and set rem=amt.
  - If amt=0 or op is reserved, go to DONE.
  - Otherwise go to SHIFT.
- SHIFT: each cycle, k=min(STEP, rem) and the working register shifts by k.
  - SLL: fill 0 at LSB.
  - SRL: fill 0 at MSB.
  - SRA: fill with the latched sign bit.
  - ROL/ROR: bits wrap around.
  - rem decrements by k. When rem reaches 0, go to DONE.
- DONE: out_valid=1 and result holds the working register. On out_ready, go to IDLE.
- in_ready=0 in SHIFT and DONE. in_valid is ignored there and no request is queued.
- Reserved op: result = data unchanged; carry_out=0.
- Operand inputs are sampled only at accept. Later changes have no effect.
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, rem=0, carry_out=0.
- Reset mid-operation: the current operation is abandoned with no partial output. The unit is in IDLE the cycle after reset deasserts.

## Timing
- Accept happens on the edge where in_valid && in_ready.
- Latency from the accept edge to out_valid high is 1 + ceil(amt/STEP) cycles; amt=0 gives 1.
- Maximum latency is 1 + ceil((WIDTH-1)/STEP).
- Back-to-back operation: after the out_valid && out_ready edge, in_ready=1 in the next cycle. Throughput is therefore at most one op per latency+2 cycles.
- result and out_valid are registered outputs. They stay stable while out_valid=1 and out_ready=0.
- in_ready is a pure decode of state; it has no combinational path from in_valid.

## Configuration
- SHIFTER_CARRY_EN defined:
  - The carry_out port exists. It updates on each SHIFT cycle to the last bit shifted out (for rotates, the bit that wrapped).
  - It is cleared on accept and valid alongside result.
  - For amt=0 or a reserved op it is 0.
- SHIFTER_CARRY_EN undefined: the port and its register are absent; all other behaviour is identical.

## Structure
- Package shifter_pkg holds the op encoding as enum shift_op_t, the FSM state enum, and a constant for the reserved-op threshold (5).
- Sub-module shift_step: combinational single-step shifter.
  - Inputs: value, op, k (≤ STEP), sign bit.
  - Outputs: shifted value and the bit shifted out.
  - Instantiated once; the FSM lives in iter_shifter.

## Test plan
Bench uses WIDTH=32, STEP=4.
- SLL data=0x00000001, amt=5 → result 0x00000020; out_valid 3 cycles after accept.
- SRA data=0xFFFFFFFE, amt=1 → 0xFFFFFFFF; SRL with the same operands → 0x7FFFFFFF; each with latency 2.
- ROR data=0x00000001, amt=31 → 0x00000002, latency 9; ROL data=0x80000000, amt=4 → 0x00000008.
- amt=0, and separately op=6 with data=0xDEADBEEF → result 0xDEADBEEF one cycle after accept, carry_out=0.
  - With SHIFTER_CARRY_EN, SLL data=0x80000001, amt=1 → result 0x00000002, carry_out=1.
- Backpressure: hold out_ready=0 for 5 cycles and pulse in_valid during them → result stable, in_ready=0, no second accept.
- Reset asserted during SHIFT (amt=20) → next cycle out_valid=0, result=0, in_ready=1; a new request then completes correctly.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shift/rotate unit: operation encoding,
// controller states and the reserved-operation decode.
package shifter_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Encodings at or above this value are reserved and pass data through.
    localparam logic [2:0] OP_RSVD_MIN = 3'd5;

    function automatic logic op_is_reserved(input logic [2:0] op);
        return (op >= OP_RSVD_MIN);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves a value by k (0..STEP) positions
// in the requested direction and mode. When SHIFTER_CARRY_EN is defined it
// also reports the last bit pushed out (for rotates, the bit that wrapped).
module shift_step
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 4,
    localparam int KW    = $clog2(STEP + 1),
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    input  shift_op_t        op,
    input  logic [KW-1:0]    k,
    input  logic             sign,
    output logic [WIDTH-1:0] shifted
`ifdef SHIFTER_CARRY_EN
    ,
    output logic             bit_out
`endif
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [AW:0] k_ext_s;
    logic [AW:0] back_s;

    // k widened to hold WIDTH; back_s is the complementary distance used for
    // wrap-around and for locating the bit leaving the MSB end. For k=0 it is
    // WIDTH, which shifts everything out and contributes nothing.
    assign k_ext_s = (AW + 1)'(k);
    assign back_s  = (AW + 1)'(WIDTH) - k_ext_s;

`ifdef SHIFTER_CARRY_EN
    logic left_bit_s;
    logic right_bit_s;

    // Bit leaving the MSB end is value[WIDTH-k]; bit leaving the LSB end is
    // value[k-1]. With k=0 both masks shift out of range and read 0.
    assign left_bit_s  = |(value & (ONE << back_s));
    assign right_bit_s = |(value & (ONE << (k_ext_s - (AW + 1)'(1))));
`endif

    // Mode-dependent shift with the appropriate fill.
    always_comb begin
        shifted = value;
`ifdef SHIFTER_CARRY_EN
        bit_out = 1'b0;
`endif
        case (op)
            OP_SLL: begin
                shifted = value << k_ext_s;
`ifdef SHIFTER_CARRY_EN
                bit_out = left_bit_s;
`endif
            end
            OP_SRL: begin
                shifted = value >> k_ext_s;
`ifdef SHIFTER_CARRY_EN
                bit_out = right_bit_s;
`endif
            end
            OP_SRA: begin
                shifted = (value >> k_ext_s) | (~(ALL_ONES >> k_ext_s) & {WIDTH{sign}});
`ifdef SHIFTER_CARRY_EN
                bit_out = right_bit_s;
`endif
            end
            OP_ROL: begin
                shifted = (value << k_ext_s) | (value >> back_s);
`ifdef SHIFTER_CARRY_EN
                bit_out = left_bit_s;
`endif
            end
            OP_ROR: begin
                shifted = (value >> k_ext_s) | (value << back_s);
`ifdef SHIFTER_CARRY_EN
                bit_out = right_bit_s;
`endif
            end
            default: begin
                shifted = value;
`ifdef SHIFTER_CARRY_EN
                bit_out = 1'b0;
`endif
            end
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Iterative shift/rotate unit with valid/ready handshakes. Shifts up to STEP
// positions per clock. Optional feature macro: SHIFTER_CARRY_EN adds the
// carry_out port reporting the last bit shifted out.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 4,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data,
    input  logic [AW-1:0]    amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
`ifdef SHIFTER_CARRY_EN
    ,
    output logic             carry_out
`endif
);

    localparam int          KW     = $clog2(STEP + 1);
    localparam logic [AW:0] STEP_W = (AW + 1)'(STEP);
    localparam logic [KW-1:0] STEP_K = KW'(STEP);

    state_t           state_r;
    state_t           state_nx;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] work_r;
    logic [AW-1:0]    rem_r;
    logic             sign_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [KW-1:0]    k_s;
    logic             last_step_s;
    logic [WIDTH-1:0] step_value_s;
`ifdef SHIFTER_CARRY_EN
    logic             carry_r;
    logic             step_bit_s;
`endif

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .value   (work_r),
        .op      (shift_op_t'(op_r)),
        .k       (k_s),
        .sign    (sign_r),
        .shifted (step_value_s)
`ifdef SHIFTER_CARRY_EN
        ,
        .bit_out (step_bit_s)
`endif
    );

    // Step size for this cycle: the full STEP, or whatever remains if less.
    always_comb begin
        k_s         = STEP_K;
        last_step_s = 1'b0;
        if ({1'b0, rem_r} <= STEP_W) begin
            k_s         = KW'(rem_r);
            last_step_s = 1'b1;
        end else begin
            k_s         = STEP_K;
            last_step_s = 1'b0;
        end
    end

    // Next-state logic. Zero amounts and reserved ops skip straight to DONE;
    // SHIFT leaves on the edge that consumes the final step.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    if ((amt == '0) || op_is_reserved(op)) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = SHIFT;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            SHIFT: begin
                if (last_step_s) begin
                    state_nx = DONE;
                end else begin
                    state_nx = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = DONE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Registered handshake flags, decoded from the upcoming state so they
    // line up with state_r and never depend combinationally on in_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_nx == IDLE);
            out_valid_r <= (state_nx == DONE);
        end
    end

    // Operand capture on accept, then one step per SHIFT cycle; DONE holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r   <= 3'd0;
            work_r <= '0;
            rem_r  <= '0;
            sign_r <= 1'b0;
`ifdef SHIFTER_CARRY_EN
            carry_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        op_r   <= op;
                        work_r <= data;
                        rem_r  <= amt;
                        sign_r <= data[WIDTH-1];
`ifdef SHIFTER_CARRY_EN
                        carry_r <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    work_r <= step_value_s;
                    rem_r  <= rem_r - AW'(k_s);
`ifdef SHIFTER_CARRY_EN
                    carry_r <= step_bit_s;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = work_r;
`ifdef SHIFTER_CARRY_EN
    assign carry_out = carry_r;
`endif

endmodule

// File: tb/tb_iter_shifter.sv
// Directed, table-driven bench for iter_shifter (WIDTH=32, STEP=4), plus
// hand-written backpressure and mid-operation reset sequences.
module tb_iter_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] data;
    logic [4:0]  amt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
`ifdef SHIFTER_CARRY_EN
    logic        carry_out;
`endif

    int n_pass  = 0;
    int n_total = 0;

    iter_shifter #(.WIDTH(32), .STEP(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .data      (data),
        .amt       (amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef SHIFTER_CARRY_EN
        ,
        .carry_out (carry_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [4:0]  amt;
        logic [31:0] exp_res;
        int          exp_lat;
        logic        exp_carry;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Offer one request, accept it, scramble the operand inputs, then wait for
    // out_valid. lat counts the accept cycle as 0.
    task automatic do_op(input logic [2:0] o, input logic [31:0] d, input logic [4:0] a,
                         output logic [31:0] r, output int lat, output logic c, output bit ok);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        op = o; data = d; amt = a; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 3'd0; data = ~d; amt = ~a;
        lat = 1;
        ok  = 1'b0;
        while (lat < 40) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        r = result;
`ifdef SHIFTER_CARRY_EN
        c = carry_out;
`else
        c = 1'b0;
`endif
    endtask

    initial begin
        logic [31:0] r;
        int          lat;
        logic        c;
        bit          ok;

        vecs[0]  = '{3'd0, 32'h0000_0001, 5'd5,  32'h0000_0020, 3, 1'b0};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFE, 5'd1,  32'hFFFF_FFFF, 2, 1'b0};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFE, 5'd1,  32'h7FFF_FFFF, 2, 1'b0};
        vecs[3]  = '{3'd4, 32'h0000_0001, 5'd31, 32'h0000_0002, 9, 1'b0};
        vecs[4]  = '{3'd3, 32'h8000_0000, 5'd4,  32'h0000_0008, 2, 1'b0};
        vecs[5]  = '{3'd0, 32'h1234_5678, 5'd0,  32'h1234_5678, 1, 1'b0};
        vecs[6]  = '{3'd6, 32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF, 1, 1'b0};
        vecs[7]  = '{3'd0, 32'h8000_0001, 5'd1,  32'h0000_0002, 2, 1'b1};
        vecs[8]  = '{3'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9, 1'b0};
        vecs[9]  = '{3'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 9, 1'b0};
        vecs[10] = '{3'd3, 32'h1234_5678, 5'd8,  32'h3456_7812, 3, 1'b0};
        vecs[11] = '{3'd0, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFF0, 2, 1'b1};
        vecs[12] = '{3'd4, 32'h0000_0001, 5'd1,  32'h8000_0000, 2, 1'b1};
        vecs[13] = '{3'd7, 32'hCAFE_F00D, 5'd0,  32'hCAFE_F00D, 1, 1'b0};
        vecs[14] = '{3'd2, 32'h7FFF_FFFF, 5'd3,  32'h0FFF_FFFF, 2, 1'b1};

        reset = 1'b1; in_valid = 1'b0; op = 3'd0; data = 32'h0; amt = 5'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_in_ready",  {31'h0, in_ready},  32'h1);
        chk("reset_result",    result,             32'h0);

        // Table of single operations, each followed by a handshake cycle.
        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i].op, vecs[i].data, vecs[i].amt, r, lat, c, ok);
            if (!ok) chk($sformatf("v%0d_timeout", i), 32'h0, 32'h1);
            chk($sformatf("v%0d_result", i),  r,           vecs[i].exp_res);
            chk($sformatf("v%0d_latency", i), 32'(lat),    32'(vecs[i].exp_lat));
`ifdef SHIFTER_CARRY_EN
            chk($sformatf("v%0d_carry", i),   {31'h0, c},  {31'h0, vecs[i].exp_carry});
`endif
            @(posedge clk); #1;
            chk($sformatf("v%0d_ready_after", i), {31'h0, in_ready}, 32'h1);
        end

        // Backpressure: result held, new requests ignored while DONE stalls.
        out_ready = 1'b0;
        do_op(3'd0, 32'h0000_0001, 5'd5, r, lat, c, ok);
        if (!ok) chk("bp_timeout", 32'h0, 32'h1);
        chk("bp_result", r, 32'h0000_0020);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = 3'd3; data = 32'hAAAA_5555; amt = 5'd1;
            @(posedge clk); #1;
            chk($sformatf("bp%0d_result", i),    result,              32'h0000_0020);
            chk($sformatf("bp%0d_out_valid", i), {31'h0, out_valid},  32'h1);
            chk($sformatf("bp%0d_in_ready", i),  {31'h0, in_ready},   32'h0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", {31'h0, out_valid}, 32'h0);
        chk("bp_release_in_ready",  {31'h0, in_ready},  32'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_second_accept", {31'h0, out_valid}, 32'h0);

        // Reset in the middle of a long shift.
        op = 3'd0; data = 32'h0000_0001; amt = 5'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mid_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_mid_result",    result,             32'h0);
        chk("rst_mid_in_ready",  {31'h0, in_ready},  32'h1);
        repeat (8) @(posedge clk);
        #1;
        chk("rst_mid_no_output", {31'h0, out_valid}, 32'h0);
        do_op(3'd0, 32'h0000_0001, 5'd20, r, lat, c, ok);
        if (!ok) chk("post_rst_timeout", 32'h0, 32'h1);
        chk("post_rst_result",  r,        32'h0010_0000);
        chk("post_rst_latency", 32'(lat), 32'd6);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
